// File: rtl/weight_ram_loader.sv
// Packs a 32-bit DMA beat stream into ByteWidth-byte words and writes them to a local RAM.
// Optional WLOAD_CHECKSUM_EN macro builds a running sum of accepted beats on checksum.
module weight_ram_loader #(
    parameter int ByteWidth = 12,
    parameter int AddrWidth = 6,
    parameter int InWidth   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [InWidth-1:0]     s_tdata,
    input  logic                   s_tvalid,
    input  logic                   s_tlast,
    output logic                   s_tready,
    input  logic [AddrWidth-1:0]   rd_addr,
    output logic [ByteWidth*8-1:0] rd_dout,
    output logic                   busy,
    output logic                   done,
    output logic [AddrWidth:0]     word_cnt,
    output logic                   err_overflow,
    output logic [31:0]            checksum
);

    localparam int WordW = ByteWidth * 8;
    localparam int BPW   = WordW / InWidth;
    localparam int BidxW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int Depth = 2 ** AddrWidth;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                 state_q, state_d;
    logic [BidxW-1:0]       bidx_q, bidx_d;
    logic [AddrWidth-1:0]   wr_addr_q, wr_addr_d;
    logic [AddrWidth:0]     word_cnt_q, word_cnt_d;
    logic                   err_q, err_d;
    logic [WordW-1:0]       pack_q, pack_d;
    logic [WordW-1:0]       packed_w;
    logic [WordW-1:0]       wdata;
    logic                   we;
    logic                   hs;
    logic [WordW-1:0]       rd_q;
    logic [WordW-1:0]       mem [Depth];

    function automatic logic [WordW-1:0] lane_insert(input logic [WordW-1:0] w,
                                                     input logic [BidxW-1:0] k,
                                                     input logic [InWidth-1:0] d);
        logic [WordW-1:0] r;
        r = w;
        r[k*InWidth +: InWidth] = d;
        return r;
    endfunction

`ifdef WLOAD_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;
`endif

    assign hs       = s_tvalid & (state_q == LOAD);
    assign packed_w = lane_insert(pack_q, bidx_q, s_tdata);

    always_comb begin
        state_d    = state_q;
        bidx_d     = bidx_q;
        wr_addr_d  = wr_addr_q;
        word_cnt_d = word_cnt_q;
        err_d      = err_q;
        pack_d     = pack_q;
        we         = 1'b0;
        wdata      = packed_w;
`ifdef WLOAD_CHECKSUM_EN
        cks_d      = cks_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = LOAD;
                    bidx_d     = '0;
                    wr_addr_d  = '0;
                    word_cnt_d = '0;
                    err_d      = 1'b0;
                    pack_d     = '0;
`ifdef WLOAD_CHECKSUM_EN
                    cks_d      = '0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
`ifdef WLOAD_CHECKSUM_EN
                    cks_d = cks_q + 32'(s_tdata);
`endif
                    // Unfilled upper lanes are already zero because pack clears after each write.
                    if (s_tlast || (bidx_q == BidxW'(BPW - 1))) begin
                        we         = 1'b1;
                        wr_addr_d  = wr_addr_q + 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        bidx_d     = '0;
                        pack_d     = '0;
                        if (s_tlast) begin
                            state_d = DONE;
                        end else if (wr_addr_q == {AddrWidth{1'b1}}) begin
                            state_d = DONE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        pack_d = packed_w;
                        bidx_d = bidx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bidx_q     <= '0;
            wr_addr_q  <= '0;
            word_cnt_q <= '0;
            err_q      <= 1'b0;
            pack_q     <= '0;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            bidx_q     <= bidx_d;
            wr_addr_q  <= wr_addr_d;
            word_cnt_q <= word_cnt_d;
            err_q      <= err_d;
            pack_q     <= pack_d;
            rd_q       <= mem[rd_addr];
        end
    end

    // RAM array has no reset; reads see pre-write data on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr_q] <= wdata;
        end
    end

`ifdef WLOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cks_q <= '0;
        else        cks_q <= cks_d;
    end
    assign checksum = cks_q;
`else
    assign checksum = 32'h0;
`endif

    assign s_tready     = (state_q == LOAD);
    assign busy         = (state_q == LOAD);
    assign done         = (state_q == DONE);
    assign word_cnt     = word_cnt_q;
    assign err_overflow = err_q;
    assign rd_dout      = rd_q;

endmodule

// File: tb/tb_weight_ram_loader.sv
// Directed bench for weight_ram_loader: table of short loads plus hand-written corner sequences.
module tb_weight_ram_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic [5:0]  rd_addr;
    logic [95:0] rd_dout;
    logic        busy;
    logic        done;
    logic [6:0]  word_cnt;
    logic        err_overflow;
    logic [31:0] checksum;

    int tests = 0;
    int fails = 0;

    weight_ram_loader #(.ByteWidth(12), .AddrWidth(6), .InWidth(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .rd_addr(rd_addr), .rd_dout(rd_dout),
        .busy(busy), .done(done), .word_cnt(word_cnt),
        .err_overflow(err_overflow), .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nbeats;
        logic [31:0] base;
        logic [6:0]  exp_cnt;
        logic [95:0] exp_last;
        logic [31:0] exp_sum;
    } vec_t;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic start_load();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        @(negedge clk);
        s_tdata  = d;
        s_tvalid = 1'b1;
        s_tlast  = l;
        while (!s_tready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: got s_tready=0, expected 1 within 50 cycles");
        end else begin
            @(posedge clk);
        end
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic rd(input int a, output logic [95:0] q);
        @(negedge clk);
        rd_addr = 6'(a);
        @(negedge clk);
        q = rd_dout;
    endtask

    function automatic logic [31:0] gdat(input int i);
        return 32'hC0DE0000 + 32'(i);
    endfunction

    vec_t        tbl[5];
    logic [95:0] q;
    logic [31:0] exp_cks;

    initial begin
        tbl[0] = '{3, 32'h11111111, 7'd1, 96'h33333333_22222222_11111111, 32'h66666666};
        tbl[1] = '{4, 32'h0A0A0A0A, 7'd2, {64'h0, 32'h28282828},          32'h64646464};
        tbl[2] = '{1, 32'hDEADBEEF, 7'd1, {64'h0, 32'hDEADBEEF},          32'hDEADBEEF};
        tbl[3] = '{5, 32'h01000001, 7'd2, {32'h0, 32'h05000005, 32'h04000004}, 32'h0F00000F};
        tbl[4] = '{6, 32'h00000010, 7'd2, {32'h60, 32'h50, 32'h40},      32'h00000150};

        rst_n = 1'b0; start = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; rd_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_tready", 96'(s_tready), 96'd0);
        check("rst_busy", 96'(busy), 96'd0);
        check("rst_done", 96'(done), 96'd0);
        check("rst_err", 96'(err_overflow), 96'd0);
        check("rst_cnt", 96'(word_cnt), 96'd0);
        check("rst_dout", rd_dout, 96'd0);
        check("rst_cks", 96'(checksum), 96'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_tready", 96'(s_tready), 96'd0);

        for (int t = 0; t < 5; t++) begin
            start_load();
            check($sformatf("v%0d_busy_after_start", t), 96'(busy), 96'd1);
            check($sformatf("v%0d_done_drops", t), 96'(done), 96'd0);
            for (int i = 0; i < tbl[t].nbeats; i++)
                beat(tbl[t].base * 32'(i + 1), (i == tbl[t].nbeats - 1));
            check($sformatf("v%0d_cnt", t), 96'(word_cnt), 96'(tbl[t].exp_cnt));
            check($sformatf("v%0d_done", t), 96'(done), 96'd1);
            check($sformatf("v%0d_err", t), 96'(err_overflow), 96'd0);
            check($sformatf("v%0d_tready", t), 96'(s_tready), 96'd0);
`ifdef WLOAD_CHECKSUM_EN
            exp_cks = tbl[t].exp_sum;
`else
            exp_cks = 32'h0;
`endif
            check($sformatf("v%0d_cks", t), 96'(checksum), 96'(exp_cks));
            rd(int'(tbl[t].exp_cnt) - 1, q);
            check($sformatf("v%0d_word", t), q, tbl[t].exp_last);
        end

        // Empty load, then start while loading is ignored.
        start_load();
        repeat (3) @(negedge clk);
        check("empty_cnt", 96'(word_cnt), 96'd0);
        check("empty_busy", 96'(busy), 96'd1);
        beat(32'h5, 1'b0);
        start_load();
        check("start_in_load_busy", 96'(busy), 96'd1);
        beat(32'h6, 1'b1);
        check("start_in_load_cnt", 96'(word_cnt), 96'd1);
        rd(0, q);
        check("start_in_load_word", q, {64'h0, 32'h6, 32'h5});

        // Overflow: 192 beats without tlast fill all 64 words.
        start_load();
        for (int i = 0; i < 192; i++) beat(32'(i), 1'b0);
        check("ovf_err", 96'(err_overflow), 96'd1);
        check("ovf_cnt", 96'(word_cnt), 96'd64);
        check("ovf_done", 96'(done), 96'd1);
        @(negedge clk);
        s_tvalid = 1'b1; s_tdata = 32'hBAD0BAD0;
        repeat (2) @(negedge clk);
        check("ovf_tready", 96'(s_tready), 96'd0);
        check("ovf_cnt_hold", 96'(word_cnt), 96'd64);
        s_tvalid = 1'b0;
        rd(0, q);
        check("ovf_word0", q, {32'd2, 32'd1, 32'd0});
        rd(63, q);
        check("ovf_word63", q, {32'd191, 32'd190, 32'd189});

        start_load();
        for (int i = 0; i < 192; i++) beat(32'(i) + 32'h100, (i == 191));
        check("full_tlast_err", 96'(err_overflow), 96'd0);
        check("full_tlast_cnt", 96'(word_cnt), 96'd64);
        rd(63, q);
        check("full_tlast_word63", q, {32'h1BF, 32'h1BE, 32'h1BD});

        // Gap-free and gapped runs both checked against the packing model.
        for (int pass = 0; pass < 2; pass++) begin
            start_load();
            for (int i = 0; i < 30; i++) begin
                if (pass == 1) repeat ($urandom_range(0, 1)) @(negedge clk);
                beat(gdat(i), (i == 29));
            end
            check($sformatf("gap%0d_cnt", pass), 96'(word_cnt), 96'd10);
            for (int w = 0; w < 10; w++) begin
                rd(w, q);
                check($sformatf("gap%0d_word%0d", pass, w), q,
                      {gdat(3*w+2), gdat(3*w+1), gdat(3*w)});
            end
        end

        // Reset in the middle of a load.
        start_load();
        for (int i = 0; i < 6; i++) beat(32'hA0 + 32'(i), (i == 5));
        start_load();
        for (int i = 0; i < 5; i++) beat(32'hB0 + 32'(i), 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_tready", 96'(s_tready), 96'd0);
        check("mid_rst_busy", 96'(busy), 96'd0);
        check("mid_rst_cnt", 96'(word_cnt), 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, q);
        check("mid_rst_word0", q, {32'hB2, 32'hB1, 32'hB0});
        rd(1, q);
        check("mid_rst_word1_kept", q, {32'hA5, 32'hA4, 32'hA3});
        start_load();
        for (int i = 0; i < 3; i++) beat(32'hC0 + 32'(i), (i == 2));
        check("reload_cnt", 96'(word_cnt), 96'd1);
        rd(0, q);
        check("reload_word0", q, {32'hC2, 32'hC1, 32'hC0});
        rd(1, q);
        check("reload_word1_kept", q, {32'hA5, 32'hA4, 32'hA3});

        // Checksum wraps mod 2**32.
        start_load();
        beat(32'hFFFFFFFF, 1'b0);
        beat(32'h00000002, 1'b1);
`ifdef WLOAD_CHECKSUM_EN
        exp_cks = 32'h00000001;
`else
        exp_cks = 32'h0;
`endif
        check("cks_wrap", 96'(checksum), 96'(exp_cks));
        repeat (2) @(negedge clk);
        check("cks_stable_done", 96'(checksum), 96'(exp_cks));
        rd(0, q);
        check("cks_word0", q, {64'h0, 32'h00000002, 32'hFFFFFFFF} & {32'h0, 64'hFFFFFFFF_FFFFFFFF});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1);
    end

endmodule
